// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the SRAM controller: default geometry and FSM states.
package ram_ctrl_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH      = 512;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/ram_rsp_fifo.sv
// Two-entry response FIFO with valid/ready on both sides; holds read data in
// request order and keeps the head stable until it is popped.
module ram_rsp_fifo #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        cnt_q;
  logic [1:0]        cnt_d;
  logic              push;
  logic              pop;

  // A full FIFO can still take a push in the cycle its head is popped.
  assign in_ready  = (cnt_q != 2'd2) || out_ready;
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = cnt_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Occupancy next-state: a simultaneous push and pop leaves it unchanged.
  always_comb begin
    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    cnt_d = cnt_q + 2'(push) - 2'(pop);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    if (rst) begin
      // NOTE: the two entries are reset because the head drives rsp_rdata, which must read 0
      // out of reset; a real RAM array would be left unreset.
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_data;
        wr_ptr_q        <= !wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= !rd_ptr_q;
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ram_ctrl.sv
// Single-port SRAM controller: zero-fills the macro after reset, then turns a
// valid/ready request stream into registered macro cycles and returns read
// data in order through a small response FIFO.
module ram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_done,
  output logic [ADDR_W-1:0] ram_a,
  output logic [DATA_W-1:0] ram_d,
  output logic              ram_cen,
  output logic              ram_wen,
  input  logic [DATA_W-1:0] ram_q
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              init_done_q, init_done_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [DATA_W-1:0] ram_d_q, ram_d_d;
  logic              ram_cen_q, ram_cen_d;
  logic              ram_wen_q, ram_wen_d;
  logic              rd_pend_q, rd_pend_d;

  logic              accept;
  logic              last_clr;
  logic              rsp_pop;
  logic              fifo_in_ready;
  logic [1:0]        fifo_count;
  logic [1:0]        occupancy;

  assign last_clr = (clr_cnt_q == '1);
  assign rsp_pop  = rsp_valid && rsp_ready;

  // Credits the entry leaving this cycle so reads can stream one per cycle.
  assign occupancy = fifo_count + 2'(rd_pend_q) - 2'(rsp_pop);
  assign req_ready = (state_q == RUN) && init_done_q && fifo_in_ready
                     && (occupancy < 2'd2);
  assign accept    = req_valid && req_ready;

  assign init_done = init_done_q;
  assign ram_a     = ram_a_q;
  assign ram_d     = ram_d_q;
  assign ram_cen   = ram_cen_q;
  assign ram_wen   = ram_wen_q;

  // State register plus all registered macro pins and the in-flight read flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR_ON_RESET ? CLEAR : RUN;
      clr_cnt_q   <= '0;
      init_done_q <= 1'b0;
      ram_a_q     <= '0;
      ram_d_q     <= '0;
      ram_cen_q   <= 1'b1;
      ram_wen_q   <= 1'b1;
      rd_pend_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      init_done_q <= init_done_d;
      ram_a_q     <= ram_a_d;
      ram_d_q     <= ram_d_d;
      ram_cen_q   <= ram_cen_d;
      ram_wen_q   <= ram_wen_d;
      rd_pend_q   <= rd_pend_d;
    end
  end

  // Next state: walk the clear counter to the last address, then stay in RUN.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    init_done_d = init_done_q;
    if (state_q == CLEAR) begin
      if (last_clr) begin
        state_d = RUN;
      end else begin
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
      end
    end
    if (state_d == RUN) begin
      init_done_d = 1'b1;
    end
  end

  // Output next-values: a zero write per clear cycle, or the accepted request;
  // otherwise the macro is deselected.
  always_comb begin
    ram_a_d   = ram_a_q;
    ram_d_d   = ram_d_q;
    ram_cen_d = 1'b1;
    ram_wen_d = 1'b1;
    rd_pend_d = 1'b0;
    if (state_q == CLEAR) begin
      ram_a_d   = clr_cnt_q;
      ram_d_d   = '0;
      ram_cen_d = 1'b0;
      ram_wen_d = 1'b0;
    end else if (accept) begin
      ram_a_d   = req_addr;
      ram_d_d   = req_wdata;
      ram_cen_d = 1'b0;
      ram_wen_d = !req_we;
      rd_pend_d = !req_we;
    end
  end

  // Read data is captured from ram_q one edge after the request reached the pins.
  ram_rsp_fifo #(
    .DATA_W(DATA_W)
  ) u_rsp_fifo (
    .clk      (clk),
    .rst      (rst),
    .in_valid (rd_pend_q),
    .in_ready (fifo_in_ready),
    .in_data  (ram_q),
    .out_valid(rsp_valid),
    .out_ready(rsp_ready),
    .out_data (rsp_rdata),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_ram_ctrl.sv
// Self-checking bench for ram_ctrl: a behavioural SRAM macro on ~clk, a
// memory-image reference model and an in-order expected-response queue.
module tb_ram_ctrl;

  localparam int AW    = 9;
  localparam int DW    = 8;
  localparam int DEPTH = 512;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          init_done;
  logic [AW-1:0] ram_a;
  logic [DW-1:0] ram_d;
  logic          ram_cen;
  logic          ram_wen;
  logic [DW-1:0] ram_q;

  always #5 clk = ~clk;

  ram_ctrl #(
    .ADDR_W        (AW),
    .DATA_W        (DW),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .init_done(init_done),
    .ram_a    (ram_a),
    .ram_d    (ram_d),
    .ram_cen  (ram_cen),
    .ram_wen  (ram_wen),
    .ram_q    (ram_q)
  );

  // Behavioural single-port macro, clocked on the falling edge.
  logic [DW-1:0] sram [DEPTH];
  always @(negedge clk) begin
    if (!ram_cen) begin
      if (!ram_wen) sram[ram_a] <= ram_d;
      else          ram_q       <= sram[ram_a];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state.
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  bit            prev_acc = 0;
  bit            prev_we  = 0;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_wdata;
  bit            hold_valid = 0;
  logic [DW-1:0] hold_data;
  bit            last_acc;
  bit            seen_ready;
  int            last_wait;

  task automatic check_reset_outputs(string tag);
    check({tag, "_cen"},   ram_cen,   1);
    check({tag, "_wen"},   ram_wen,   1);
    check({tag, "_a"},     ram_a,     0);
    check({tag, "_d"},     ram_d,     0);
    check({tag, "_ready"}, req_ready, 0);
    check({tag, "_rspv"},  rsp_valid, 0);
    check({tag, "_rdata"}, rsp_rdata, 0);
    check({tag, "_init"},  init_done, 0);
  endtask

  // One RUN cycle: check pins and responses at the falling edge, update the
  // model from whatever handshakes happened, then step past the rising edge.
  task automatic do_cycle();
    bit in_reset;
    @(negedge clk);
    in_reset   = rst;
    last_acc   = 0;
    seen_ready = req_ready;
    if (!in_reset) begin
      check("init_hold", init_done, 1);
      if (prev_acc) begin
        check("pin_cen", ram_cen, 0);
        check("pin_wen", ram_wen, !prev_we);
        check("pin_a",   ram_a,   prev_addr);
        if (prev_we) check("pin_d", ram_d, prev_wdata);
      end else begin
        check("idle_cen", ram_cen, 1);
        check("idle_wen", ram_wen, 1);
      end
      if (hold_valid) begin
        check("hold_valid", rsp_valid, 1);
        check("hold_data",  rsp_rdata, hold_data);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) check("rsp_unexpected", rsp_valid, 0);
        else                   check("rsp_data", rsp_rdata, exp_q.pop_front());
      end
      hold_valid = rsp_valid && !rsp_ready;
      hold_data  = rsp_rdata;
      last_acc   = req_valid && req_ready;
      if (last_acc) begin
        if (req_we) model_mem[req_addr] = req_wdata;
        else        exp_q.push_back(model_mem[req_addr]);
      end
      prev_acc   = last_acc;
      prev_we    = req_we;
      prev_addr  = req_addr;
      prev_wdata = req_wdata;
    end else begin
      prev_acc   = 0;
      hold_valid = 0;
    end
    @(posedge clk);
    #1;
    if (in_reset) begin
      exp_q.delete();
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    end
  endtask

  // Follows the zero-fill from the first post-reset cycle until init_done.
  task automatic wait_init();
    int  n_clr = 0;
    int  cyc   = 0;
    bit  done  = 0;
    prev_acc   = 0;
    hold_valid = 0;
    for (int i = 0; i < 600 && !done; i++) begin
      @(negedge clk);
      if (i == 0) check_reset_outputs("post_rst");
      if (!ram_cen) begin
        check("clr_addr", ram_a, n_clr);
        check("clr_wen",  ram_wen, 0);
        check("clr_d",    ram_d, 0);
        n_clr++;
      end
      if (!init_done) check("clr_ready", req_ready, 0);
      if (init_done) begin
        done = 1;
      end else begin
        cyc++;
        @(posedge clk);
        #1;
      end
    end
    check("init_cycles", cyc, 512);
    check("clr_count", n_clr, 512);
    @(posedge clk);
    #1;
  endtask

  task automatic issue(bit we, int addr, int data);
    int n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = AW'(addr);
    req_wdata = DW'(data);
    do begin
      do_cycle();
      n++;
    end while (!last_acc && n < 50);
    if (!last_acc) check("issue_timeout", last_acc, 1);
    last_wait = n;
  endtask

  task automatic drain();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 20 && (exp_q.size() != 0 || rsp_valid); i++) do_cycle();
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int sum;

    // Reset values while reset is held.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("in_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    wait_init();

    // Reads of a freshly cleared array, with response latency.
    issue(0, 5, 0);
    req_valid = 1'b0;
    check("lat_t", rsp_valid, 0);
    do_cycle();
    check("lat_t1", rsp_valid, 1);
    issue(0, 511, 0);
    drain();

    // Back-to-back writes of i*i, then back-to-back reads at full rate.
    sum = 0;
    for (int i = 0; i < 64; i++) begin
      issue(1, i, (i * i) & 8'hFF);
      sum += last_wait;
    end
    check("wr_burst_cycles", sum, 64);
    sum = 0;
    for (int i = 0; i < 64; i++) begin
      issue(0, i, 0);
      sum += last_wait;
    end
    check("rd_burst_cycles", sum, 64);
    drain();

    // Backpressure: only two reads fit while the consumer stalls.
    rsp_ready = 1'b0;
    issue(0, 10, 0);
    issue(0, 11, 0);
    req_addr = AW'(12);
    repeat (4) begin
      do_cycle();
      check("bp_acc",   last_acc,   0);
      check("bp_ready", seen_ready, 0);
    end
    rsp_ready = 1'b1;
    issue(0, 12, 0);
    check("bp_release_wait", last_wait, 1);
    drain();

    // Read-after-write on consecutive cycles.
    issue(1, 9, 8'hA5);
    issue(0, 9, 0);
    check("raw_wait", last_wait, 1);
    drain();

    // Idle RUN cycles keep the macro deselected.
    req_valid = 1'b0;
    repeat (10) do_cycle();

    // Randomized traffic over a small address window to force reuse.
    for (int c = 0; c < 400; c++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = AW'($urandom_range(0, 31));
      req_wdata = DW'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      do_cycle();
    end
    drain();

    // Reset with one read in the FIFO and one in flight.
    rsp_ready = 1'b0;
    issue(0, 20, 0);
    issue(0, 21, 0);
    req_valid = 1'b0;
    rst = 1'b1;
    do_cycle();
    rst = 1'b0;
    wait_init();
    rsp_ready = 1'b1;
    issue(0, 20, 0);
    issue(0, 0, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_ctrl.md
RAM_CTRL -- requirements
Module: ram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, meaning SRAM word-address width (512 words).
REQ-002 SHALL have parameter DATA_W, default 8, meaning SRAM data width.
REQ-003 SHALL have parameter CLEAR_ON_RESET, default 1, meaning zero-fill all words after reset.
REQ-004 SHALL have port clk, input, 1, meaning single clock; every flop updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-006 SHALL have port req_valid, input, 1, meaning request present.
REQ-007 SHALL have port req_ready, output, 1, meaning request accepted this cycle when req_valid is also high.
REQ-008 SHALL have port req_we, input, 1, meaning 1 = write, 0 = read.
REQ-009 SHALL have port req_addr, input, ADDR_W, meaning word address.
REQ-010 SHALL have port req_wdata, input, DATA_W, meaning write data.
REQ-011 SHALL have port rsp_valid, output, 1, meaning read data available.
REQ-012 SHALL have port rsp_ready, input, 1, meaning consumer takes read data.
REQ-013 SHALL have port rsp_rdata, output, DATA_W, meaning read data, in request order.
REQ-014 SHALL have port init_done, output, 1, meaning clear sequence finished.
REQ-015 SHALL have ports ram_a (ADDR_W), ram_d (DATA_W), ram_cen (1, active-low), ram_wen (1, active-low), all outputs, meaning macro A/D/CEN/WEN.
REQ-016 SHALL have port ram_q, input, DATA_W, meaning macro Q.

Function
REQ-017 SHALL drive ram_a, ram_d, ram_cen and ram_wen from flops only; the macro is clocked on ~clk and samples at the falling edge.
REQ-018 SHALL use the FSM states CLEAR and RUN; after reset it enters CLEAR when CLEAR_ON_RESET=1, otherwise RUN.
REQ-019 In CLEAR, SHALL write 0 to addresses 0..2^ADDR_W-1, one per cycle in ascending order, hold req_ready=0, then enter RUN after the last address with no wrap.
REQ-020 SHALL raise init_done on the first cycle in RUN and hold it until reset.
REQ-021 In RUN, a request accepted at edge T SHALL be presented on the ram_* pins from T to T+1 with ram_cen=0 and ram_wen=!req_we.
REQ-022 In any cycle with no accepted request, SHALL hold ram_cen=1 with ram_wen=1.
REQ-023 For reads, SHALL capture ram_q at edge T+1 into a 2-entry response FIFO, so rsp_valid rises one cycle after acceptance when the FIFO is empty.
REQ-024 Writes SHALL produce no response.
REQ-025 SHALL compute req_ready = RUN and (FIFO occupancy + in-flight reads) < 2, with no dependence on req_valid or req_we.
REQ-026 SHALL sustain one request per cycle while rsp_ready=1.
REQ-027 SHALL hold rsp_rdata stable while rsp_valid=1 and rsp_ready=0.
REQ-028 On a simultaneous FIFO push and pop, SHALL keep occupancy unchanged and preserve order.
REQ-029 On a write to address X at T followed by a read of X at T+1, the read SHALL return the new data.

Reset
REQ-030 While rst=1 at an edge, SHALL set ram_cen=1, ram_wen=1, ram_a=0, ram_d=0, req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0, and the clear counter to 0.
REQ-031 Reset asserted mid-operation SHALL discard any in-flight read and all FIFO contents, then restart CLEAR from address 0.

Structure
REQ-032 SHALL place ADDR_W/DATA_W defaults, DEPTH=512 and the state enum {CLEAR,RUN} in shared package ram_ctrl_pkg.
REQ-033 SHALL implement the response FIFO as sub-module ram_rsp_fifo (2 entries, valid/ready both sides).

Verification
REQ-034 SHALL cover: reset, wait for init_done (512 cycles), read addr 5 and 511 -> rsp_rdata 0x00 both.
REQ-035 SHALL cover: write addr i with (i*i)[7:0] for i=0..63 back-to-back, then read 0..63 -> 64 responses in order, e.g. addr 17 -> 0x21, addr 63 -> 0x81, zero mismatches.
REQ-036 SHALL cover: hold rsp_ready=0 and issue 3 reads -> exactly 2 accepted, req_ready=0; release -> third accepted, order preserved.
REQ-037 SHALL cover: write 0xA5 to addr 9 at T, read 9 at T+1 -> 0xA5.
REQ-038 SHALL cover: assert rst for 1 cycle during a pending read with FIFO full -> rsp_valid=0 next cycle, init_done=0, CLEAR restarts at addr 0.
REQ-039 SHALL cover: idle RUN cycles -> ram_cen=1 every cycle.
